// File: rtl/axis_pgroup_packer.sv
// Packs a narrow AXI-Stream of raw pixels into full-width pixel-group beats,
// marks the last group of each frame and steers frames round-robin via tdest.
module axis_pgroup_packer #(
  parameter int unsigned IN_W         = 32,
  parameter int unsigned OUT_W        = 256,
  parameter int unsigned IP_AMT       = 1,
  parameter int unsigned AXIS_TID_W   = 2,
  parameter int unsigned AXIS_TDEST_W = 1,
  parameter int unsigned TID_VAL      = 0,
  parameter int unsigned FRAME_PGNUM  = 2400
) (
  input  logic                     s_aclk,
  input  logic                     s_aresetn,
  input  logic [IN_W-1:0]          s_tdata_i,
  input  logic                     s_tvalid_i,
  input  logic                     s_tlast_i,
  output logic                     s_tready_o,
  output logic [AXIS_TID_W-1:0]    m_tid_o,
  output logic [AXIS_TDEST_W-1:0]  m_tdest_o,
  output logic [OUT_W-1:0]         m_tdata_o,
  output logic [OUT_W/8-1:0]       m_tkeep_o,
  output logic [OUT_W/8-1:0]       m_tstrb_o,
  output logic                     m_tlast_o,
  output logic                     m_tvalid_o,
  input  logic                     m_tready_i,
  output logic                     frame_done_o,
  output logic                     frame_err_o
);

  localparam int unsigned BEATS  = OUT_W / IN_W;
  localparam int unsigned KEEP_W = OUT_W / 8;
  localparam int unsigned WORD_B = IN_W / 8;
  localparam int unsigned ACC_W  = (BEATS - 1) * IN_W;
  localparam int unsigned BCNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned GCNT_W = (FRAME_PGNUM > 1) ? $clog2(FRAME_PGNUM) : 1;

  logic                  run_q;
  logic [BCNT_W-1:0]     beat_cnt_q;
  logic [GCNT_W-1:0]     grp_cnt_q;
  logic [ACC_W-1:0]      acc_q;

  logic                  full_beat_c;
  logic                  closes_c;
  logic                  s_fire_c;
  logic                  load_c;
  logic                  m_fire_c;
  logic                  last_grp_c;
  logic                  grp_last_c;
  logic                  grp_err_c;
  logic [OUT_W-1:0]      grp_data_c;
  logic [KEEP_W-1:0]     grp_keep_c;

  // Handshake and group-close decisions for the beat currently offered
  always_comb begin
    full_beat_c = (beat_cnt_q == BCNT_W'(BEATS - 1));
    closes_c    = full_beat_c | s_tlast_i;
    s_tready_o  = run_q & ~(closes_c & m_tvalid_o & ~m_tready_i);
    s_fire_c    = s_tvalid_i & s_tready_o;
    load_c      = s_fire_c & closes_c;
    m_fire_c    = m_tvalid_o & m_tready_i;
    last_grp_c  = (grp_cnt_q == GCNT_W'(FRAME_PGNUM - 1));
    grp_last_c  = s_tlast_i | (last_grp_c & full_beat_c);
    grp_err_c   = s_tlast_i ^ (last_grp_c & full_beat_c);
  end

  // Assemble the group: accumulated words below, incoming word at its slot, zeros above
  always_comb begin
    grp_data_c             = '0;
    grp_keep_c             = '0;
    grp_data_c[ACC_W-1:0]  = acc_q;
    for (int unsigned i = 0; i < BEATS; i++) begin
      if (BCNT_W'(i) == beat_cnt_q) grp_data_c[i*IN_W +: IN_W] = s_tdata_i;
      if (BCNT_W'(i) <= beat_cnt_q) grp_keep_c[i*WORD_B +: WORD_B] = {WORD_B{1'b1}};
    end
  end

  // Input side: accumulator and beat/group counters
  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      run_q      <= 1'b0;
      beat_cnt_q <= '0;
      grp_cnt_q  <= '0;
      acc_q      <= '0;
    end else begin
      run_q <= 1'b1;
      if (s_fire_c) begin
        if (load_c) begin
          beat_cnt_q <= '0;
          acc_q      <= '0;
          grp_cnt_q  <= grp_last_c ? '0 : grp_cnt_q + GCNT_W'(1);
        end else begin
          beat_cnt_q <= beat_cnt_q + BCNT_W'(1);
          for (int unsigned i = 0; i < BEATS - 1; i++) begin
            if (BCNT_W'(i) == beat_cnt_q) acc_q[i*IN_W +: IN_W] <= s_tdata_i;
          end
        end
      end
    end
  end

  // Output register; a load may coincide with the transfer of the previous group
  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      m_tvalid_o   <= 1'b0;
      m_tdata_o    <= '0;
      m_tkeep_o    <= '0;
      m_tlast_o    <= 1'b0;
      m_tdest_o    <= '0;
      frame_done_o <= 1'b0;
      frame_err_o  <= 1'b0;
    end else begin
      frame_done_o <= m_fire_c & m_tlast_o;
      frame_err_o  <= load_c & grp_err_c;
      if (load_c) begin
        m_tvalid_o <= 1'b1;
        m_tdata_o  <= grp_data_c;
        m_tkeep_o  <= grp_keep_c;
        m_tlast_o  <= grp_last_c;
      end else if (m_fire_c) begin
        m_tvalid_o <= 1'b0;
      end
      if (m_fire_c && m_tlast_o) begin
        m_tdest_o <= (m_tdest_o == AXIS_TDEST_W'(IP_AMT - 1)) ? '0
                                                               : m_tdest_o + AXIS_TDEST_W'(1);
      end
    end
  end

  assign m_tstrb_o = m_tkeep_o;
  assign m_tid_o   = AXIS_TID_W'(TID_VAL);

endmodule
